// File: rtl/matrix_multiplier_pkg.sv
// Shared constants and state type for the 4x16 by 16x4 matrix multiplier.
package matrix_multiplier_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ROWS      = 4;
  localparam int unsigned INNER     = 16;
  localparam int unsigned COLS      = 4;
  localparam int unsigned OUT_W     = 16;
  localparam int unsigned LANES     = 5;
  localparam int unsigned ACC_W     = 20;

  // Lanes 0..3 carry one 4-term slice of a dot product per cycle; lane 4 is idle.
  localparam int unsigned CU_LANES  = 4;
  localparam int unsigned DSP_IN_W  = 18;
  localparam int unsigned DSP_OUT_W = 37;
  localparam int unsigned PROD_W    = 17;
  localparam int unsigned PSUM_W    = 18;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } mm_state_t;

endpackage

// File: rtl/mm_lane_adder.sv
// Combinational sum of the four active DSP lane products.
module mm_lane_adder
  import matrix_multiplier_pkg::*;
(
  input  logic [PROD_W-1:0] prod [CU_LANES],
  output logic [PSUM_W-1:0] psum
);

  assign psum = PSUM_W'(prod[0]) + PSUM_W'(prod[1]) + PSUM_W'(prod[2]) + PSUM_W'(prod[3]);

endmodule

// File: rtl/matrix_multiplier.sv
// C = A x B using an external DSP lane array, four MACs per cycle, 64 cycles per run.
// Optional MATRIX_MULTIPLIER_SATURATE_EN clamps each C element instead of truncating.
module matrix_multiplier
  import matrix_multiplier_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_W-1:0]    a       [ROWS][INNER],
  input  logic [DATA_W-1:0]    b       [INNER][COLS],
  output logic [OUT_W-1:0]     c       [ROWS][COLS],
  output logic [DSP_IN_W-1:0]  dsp_a0  [LANES],
  output logic [DSP_IN_W-1:0]  dsp_b0  [LANES],
  input  logic [DSP_OUT_W-1:0] dsp_out [LANES],
  output logic                 dsp_ce,
  output logic                 done
);

  mm_state_t        state_q, state_d;
  logic [3:0]       elem_q, elem_d;
  logic [1:0]       step_q, step_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             done_q, done_d;
  logic             c_clr, c_we;
  logic [OUT_W-1:0] c_q [ROWS][COLS];

  logic [1:0]        row, col;
  logic [PROD_W-1:0] lane_prod [CU_LANES];
  logic [PSUM_W-1:0] psum;
  logic [ACC_W-1:0]  acc_final;
  logic [OUT_W-1:0]  c_elem;
  logic              unused_dsp;

  assign row = elem_q[3:2];
  assign col = elem_q[1:0];

  always_comb begin
    for (int l = 0; l < CU_LANES; l++) begin
      lane_prod[l] = dsp_out[l][PROD_W-1:0];
    end
  end

  // Product bits above the 17-bit range and lane 4 are never consumed.
  assign unused_dsp = ^{dsp_out[0][DSP_OUT_W-1:PROD_W], dsp_out[1][DSP_OUT_W-1:PROD_W],
                        dsp_out[2][DSP_OUT_W-1:PROD_W], dsp_out[3][DSP_OUT_W-1:PROD_W],
                        dsp_out[4]};

  mm_lane_adder u_lane_adder (
    .prod (lane_prod),
    .psum (psum)
  );

  assign acc_final = acc_q + ACC_W'(psum);

`ifdef MATRIX_MULTIPLIER_SATURATE_EN
  assign c_elem = (acc_final > ACC_W'(16'hFFFF)) ? 16'hFFFF : acc_final[OUT_W-1:0];
`else
  assign c_elem = acc_final[OUT_W-1:0];
`endif

  // Operands are driven straight from live a/b; the step selects k = 4*step + lane.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      dsp_a0[l] = '0;
      dsp_b0[l] = '0;
    end
    if (state_q == COMPUTE) begin
      for (int l = 0; l < CU_LANES; l++) begin
        dsp_a0[l] = DSP_IN_W'(a[row][{step_q, 2'(l)}]);
        dsp_b0[l] = DSP_IN_W'(b[{step_q, 2'(l)}][col]);
      end
    end
  end

  assign dsp_ce = (state_q == COMPUTE);
  assign done   = done_q;

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    step_d  = step_q;
    acc_d   = acc_q;
    done_d  = done_q;
    c_clr   = 1'b0;
    c_we    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = COMPUTE;
          elem_d  = '0;
          step_d  = '0;
          acc_d   = '0;
          done_d  = 1'b0;
          c_clr   = 1'b1;
        end
      end
      COMPUTE: begin
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          acc_d  = '0;
          c_we   = 1'b1;
          elem_d = elem_q + 4'd1;
          if (elem_q == 4'd15) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          acc_d = acc_final;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      elem_q  <= '0;
      step_q  <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          c_q[i][j] <= '0;
        end
      end
    end else if (c_clr) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          c_q[i][j] <= '0;
        end
      end
    end else if (c_we) begin
      c_q[row][col] <= c_elem;
    end
  end

  assign c = c_q;

endmodule

// File: tb/tb_matrix_multiplier.sv
// Self-checking bench for matrix_multiplier with a behavioural DSP and a reference model.
module tb_matrix_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a       [4][16];
  logic [7:0]  b       [16][4];
  logic [15:0] c       [4][4];
  logic [17:0] dsp_a0  [5];
  logic [17:0] dsp_b0  [5];
  logic [36:0] dsp_out [5];
  logic        dsp_ce;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  matrix_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .c       (c),
    .dsp_a0  (dsp_a0),
    .dsp_b0  (dsp_b0),
    .dsp_out (dsp_out),
    .dsp_ce  (dsp_ce),
    .done    (done)
  );

  always #5 clk = ~clk;

  // DSP slice bank: full product, with junk in the bits the DUT must ignore.
  logic [35:0] prod [5];
  always_comb begin
    for (int l = 0; l < 5; l++) begin
      prod[l]    = 36'(dsp_a0[l]) * 36'(dsp_b0[l]);
      dsp_out[l] = {20'hA5A5A, prod[l][16:0]};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain dot product, then saturate or truncate.
  function automatic logic [15:0] ref_elem(input int i, input int j);
    int sum;
    sum = 0;
    for (int k = 0; k < 16; k++) sum += int'(a[i][k]) * int'(b[k][j]);
`ifdef MATRIX_MULTIPLIER_SATURATE_EN
    if (sum > 65535) sum = 65535;
`endif
    return 16'(sum);
  endfunction

  // Model timeline: m_edges = compute edges completed; element e is final after 4*(e+1).
  logic        m_busy, m_done;
  int          m_edges;
  logic [15:0] m_res [16];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_edges <= 0;
    end else if (m_busy) begin
      m_edges <= m_edges + 1;
      if (m_edges == 63) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end else if (start) begin
      m_busy  <= 1'b1;
      m_done  <= 1'b0;
      m_edges <= 0;
      for (int e = 0; e < 16; e++) m_res[e] <= ref_elem(e / 4, e % 4);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("done", 32'(done), 32'(m_done));
      check("dsp_ce", 32'(dsp_ce), 32'(m_busy));
      check("lane4_a", 32'(dsp_a0[4]), 32'd0);
      check("lane4_b", 32'(dsp_b0[4]), 32'd0);
      for (int e = 0; e < 16; e++) begin
        check($sformatf("c[%0d][%0d]", e / 4, e % 4), 32'(c[e / 4][e % 4]),
              (m_edges >= 4 * (e + 1)) ? 32'(m_res[e]) : 32'd0);
      end
      if (!m_busy) begin
        for (int l = 0; l < 4; l++) begin
          check("idle_a", 32'(dsp_a0[l]), 32'd0);
          check("idle_b", 32'(dsp_b0[l]), 32'd0);
        end
      end
    end
  end

  task automatic set_pattern(input int kind);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 16; k++) begin
        case (kind)
          0: a[i][k] = 8'h01;
          1: a[i][k] = 8'(i + 1);
          2: a[i][k] = 8'hFF;
          default: a[i][k] = 8'($urandom_range(0, 255));
        endcase
      end
    end
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 4; j++) begin
        case (kind)
          0: b[k][j] = 8'h01;
          1: b[k][j] = 8'(j + 1);
          2: b[k][j] = 8'hFF;
          default: b[k][j] = 8'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  // Called #1 after a posedge. repulse_at / abort_at are loop cycle numbers, -1 for none.
  task automatic run(input int repulse_at, input int abort_at);
    int cyc;
    int ce_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_cleared_at_start", 32'(done), 32'd0);
    check("c00_cleared_at_start", 32'(c[0][0]), 32'd0);
    ce_cnt = dsp_ce ? 1 : 0;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == repulse_at);
      if (dsp_ce) ce_cnt++;
      if (cyc == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_done", 32'(done), 32'd0);
        check("abort_ce", 32'(dsp_ce), 32'd0);
        for (int e = 0; e < 16; e++) check("abort_c", 32'(c[e / 4][e % 4]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
    end
    start = 1'b0;
    check("done_latency", 32'(cyc), 32'd64);
    check("ce_cycles", 32'(ce_cnt), 32'd64);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    set_pattern(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_ce", 32'(dsp_ce), 32'd0);
    check("rst_c33", 32'(c[3][3]), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    set_pattern(0);
    run(-1, -1);
    for (int e = 0; e < 16; e++) check("ones_c", 32'(c[e / 4][e % 4]), 32'h0010);

    set_pattern(1);
    run(-1, -1);
    check("ramp_c00", 32'(c[0][0]), 32'h0010);
    check("ramp_c33", 32'(c[3][3]), 32'h0100);
    check("ramp_c12", 32'(c[1][2]), 32'h0060);

    set_pattern(2);
    run(-1, -1);
`ifdef MATRIX_MULTIPLIER_SATURATE_EN
    for (int e = 0; e < 16; e++) check("ff_c", 32'(c[e / 4][e % 4]), 32'hFFFF);
`else
    for (int e = 0; e < 16; e++) check("ff_c", 32'(c[e / 4][e % 4]), 32'hE010);
`endif

    set_pattern(1);
    run(10, -1);
    check("repulse_c12", 32'(c[1][2]), 32'h0060);
    check("repulse_c31", 32'(c[3][1]), 32'h0080);

    set_pattern(0);
    run(-1, 30);
    repeat (2) @(posedge clk);
    #1;
    set_pattern(1);
    run(-1, -1);
    check("post_abort_c23", 32'(c[2][3]), 32'h00C0);

    // Back-to-back: restart straight from DONE.
    set_pattern(0);
    run(-1, -1);
    set_pattern(1);
    run(-1, -1);
    check("b2b_c32", 32'(c[3][2]), 32'h00C0);

    set_pattern(3);
    run(-1, -1);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
